// File: rtl/demux_buf.sv
// demux_buf: steers one valid/ready input stream into one of two buffered
// output channels (A when in_sel=0, B when in_sel=1). Each channel owns an
// independent 2-entry FIFO, so a stalled consumer on one side never corrupts
// the other side's ordering.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_data/in_sel sampled on push
//   a_valid/a_ready     channel A handshake, a_data = A head word
//   b_valid/b_ready     channel B handshake, b_data = B head word
//   a_count/b_count     words accepted into A/B since reset, mod 256
//
// Handshake: a transfer happens on a rising edge where valid=1 and ready=1
// at that edge. valid never depends combinationally on the same interface's
// ready. in_ready depends only on in_sel and registered occupancy; channel
// outputs come straight from registers, so nothing on in_* reaches a_*/b_*
// without passing through a flop.

module demux_buf #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             in_ready,
  output logic             a_valid,
  output logic [WIDTH-1:0] a_data,
  input  logic             a_ready,
  output logic             b_valid,
  output logic [WIDTH-1:0] b_data,
  input  logic             b_ready,
  output logic [7:0]       a_count,
  output logic [7:0]       b_count
);

  // Channel A state
  logic [1:0][WIDTH-1:0] a_mem_q, a_mem_d;
  logic                  a_wr_q, a_wr_d;
  logic                  a_rd_q, a_rd_d;
  logic [1:0]            a_occ_q, a_occ_d;
  logic [7:0]            a_cnt_q, a_cnt_d;

  // Channel B state
  logic [1:0][WIDTH-1:0] b_mem_q, b_mem_d;
  logic                  b_wr_q, b_wr_d;
  logic                  b_rd_q, b_rd_d;
  logic [1:0]            b_occ_q, b_occ_d;
  logic [7:0]            b_cnt_q, b_cnt_d;

  logic push_a, push_b, pop_a, pop_b;

  // Head-of-line: readiness follows only the selected channel, even if the
  // other one has room. Gated by rst_n so nothing is accepted during reset.
  assign in_ready = rst_n & (in_sel ? (b_occ_q < 2'd2) : (a_occ_q < 2'd2));

  assign push_a = in_valid & in_ready & ~in_sel;
  assign push_b = in_valid & in_ready &  in_sel;

  assign a_valid = (a_occ_q != 2'd0);
  assign b_valid = (b_occ_q != 2'd0);
  assign a_data  = a_mem_q[a_rd_q];
  assign b_data  = b_mem_q[b_rd_q];

  // x_ready is ignored while the channel is empty, so no underflow.
  assign pop_a = a_valid & a_ready;
  assign pop_b = b_valid & b_ready;

  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;

  always_comb begin
    a_mem_d = a_mem_q;
    a_wr_d  = a_wr_q ^ push_a;
    a_rd_d  = a_rd_q ^ pop_a;
    a_occ_d = a_occ_q;
    a_cnt_d = a_cnt_q + {7'd0, push_a};
    if (push_a) a_mem_d[a_wr_q] = in_data;
    // Push and pop together leave occupancy unchanged; a push can only
    // coincide with a pop at occupancy 1 because full blocks in_ready.
    case ({push_a, pop_a})
      2'b10:   a_occ_d = a_occ_q + 2'd1;
      2'b01:   a_occ_d = a_occ_q - 2'd1;
      default: a_occ_d = a_occ_q;
    endcase
  end

  always_comb begin
    b_mem_d = b_mem_q;
    b_wr_d  = b_wr_q ^ push_b;
    b_rd_d  = b_rd_q ^ pop_b;
    b_occ_d = b_occ_q;
    b_cnt_d = b_cnt_q + {7'd0, push_b};
    if (push_b) b_mem_d[b_wr_q] = in_data;
    case ({push_b, pop_b})
      2'b10:   b_occ_d = b_occ_q + 2'd1;
      2'b01:   b_occ_d = b_occ_q - 2'd1;
      default: b_occ_d = b_occ_q;
    endcase
  end

  // Control state: cleared asynchronously, discarding any buffered words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wr_q  <= 1'b0;
      a_rd_q  <= 1'b0;
      a_occ_q <= 2'd0;
      a_cnt_q <= 8'd0;
      b_wr_q  <= 1'b0;
      b_rd_q  <= 1'b0;
      b_occ_q <= 2'd0;
      b_cnt_q <= 8'd0;
    end else begin
      a_wr_q  <= a_wr_d;
      a_rd_q  <= a_rd_d;
      a_occ_q <= a_occ_d;
      a_cnt_q <= a_cnt_d;
      b_wr_q  <= b_wr_d;
      b_rd_q  <= b_rd_d;
      b_occ_q <= b_occ_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  // Data storage carries no reset; contents are meaningless while the
  // channel's valid is low.
  always_ff @(posedge clk) begin
    a_mem_q <= a_mem_d;
    b_mem_q <= b_mem_d;
  end

endmodule

// File: tb/tb_demux_buf.sv
module tb_demux_buf;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         in_sel = 1'b0;
  logic         in_ready;
  logic         a_valid, b_valid;
  logic [W-1:0] a_data, b_data;
  logic         a_ready = 1'b0;
  logic         b_ready = 1'b0;
  logic [7:0]   a_count, b_count;

  demux_buf #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(in_ready),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .a_count(a_count), .b_count(b_count)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_a_q[$];
  logic [W-1:0] exp_b_q[$];
  logic [7:0]   m_cnt_a = 8'd0;
  logic [7:0]   m_cnt_b = 8'd0;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge; inputs settle before sampling.
  task automatic drive(input logic v, input logic [W-1:0] d, input logic s,
                       input logic ar, input logic br);
    in_valid = v;
    in_data  = d;
    in_sel   = s;
    a_ready  = ar;
    b_ready  = br;
    #1;
  endtask

  function automatic logic model_ready();
    return in_sel ? (exp_b_q.size() < 2) : (exp_a_q.size() < 2);
  endfunction

  task automatic model_check(input string tag);
    chk({tag, " in_ready"}, int'(in_ready), int'(model_ready()));
    chk({tag, " a_valid"}, int'(a_valid), int'(exp_a_q.size() != 0));
    if (exp_a_q.size() != 0) chk({tag, " a_data"}, int'(a_data), int'(exp_a_q[0]));
    chk({tag, " b_valid"}, int'(b_valid), int'(exp_b_q.size() != 0));
    if (exp_b_q.size() != 0) chk({tag, " b_data"}, int'(b_data), int'(exp_b_q[0]));
    chk({tag, " a_count"}, int'(a_count), int'(m_cnt_a));
    chk({tag, " b_count"}, int'(b_count), int'(m_cnt_b));
  endtask

  // Advance one clock, updating the model with the handshakes at that edge.
  task automatic step();
    logic rdy;
    rdy = model_ready();
    @(posedge clk);
    if (exp_a_q.size() != 0 && a_ready) void'(exp_a_q.pop_front());
    if (exp_b_q.size() != 0 && b_ready) void'(exp_b_q.pop_front());
    if (in_valid && rdy) begin
      if (in_sel) begin
        exp_b_q.push_back(in_data);
        m_cnt_b = m_cnt_b + 8'd1;
      end else begin
        exp_a_q.push_back(in_data);
        m_cnt_a = m_cnt_a + 8'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    exp_a_q.delete();
    exp_b_q.delete();
    m_cnt_a = 8'd0;
    m_cnt_b = 8'd0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         s;
    logic         ar;
    logic         br;
    logic         e_rdy;
    logic         e_av;
    logic [W-1:0] e_ad;
    logic         e_bv;
    logic [W-1:0] e_bd;
  } vec_t;

  localparam int NV = 21;
  vec_t tbl[NV];

  function automatic vec_t mk(input logic v, input logic [W-1:0] d, input logic s,
                              input logic ar, input logic br, input logic rdy,
                              input logic av, input logic [W-1:0] ad,
                              input logic bv, input logic [W-1:0] bd);
    vec_t r;
    r.v = v; r.d = d; r.s = s; r.ar = ar; r.br = br;
    r.e_rdy = rdy; r.e_av = av; r.e_ad = ad; r.e_bv = bv; r.e_bd = bd;
    return r;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic route: 0x3 to A, 0xA to B, each head visible for one cycle.
    tbl[0]  = mk(1'b1, 4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    tbl[1]  = mk(1'b1, 4'hA, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0);
    tbl[2]  = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hA);
    tbl[3]  = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    // Fill/backpressure on A, third word held, then drained in order.
    tbl[4]  = mk(1'b1, 4'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    tbl[5]  = mk(1'b1, 4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0);
    tbl[6]  = mk(1'b1, 4'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0);
    tbl[7]  = mk(1'b0, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 4'h1, 1'b0, 4'h0);
    tbl[8]  = mk(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h1, 1'b0, 4'h0);
    tbl[9]  = mk(1'b1, 4'h3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h2, 1'b0, 4'h0);
    tbl[10] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h3, 1'b0, 4'h0);
    tbl[11] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    // Simultaneous push/pop at occupancy 1.
    tbl[12] = mk(1'b1, 4'h5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);
    tbl[13] = mk(1'b1, 4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0);
    tbl[14] = mk(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 4'h0);
    // Full plus pop: no pass-through, push accepted the next cycle.
    tbl[15] = mk(1'b1, 4'h7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h6, 1'b0, 4'h0);
    tbl[16] = mk(1'b1, 4'h8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'h7, 1'b0, 4'h0);
    tbl[17] = mk(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'h7, 1'b0, 4'h0);
    tbl[18] = mk(1'b1, 4'h9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h8, 1'b0, 4'h0);
    tbl[19] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'h9, 1'b0, 4'h0);
    tbl[20] = mk(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0);

    // Reset state, with an offered word that must not be accepted.
    in_valid = 1'b1;
    in_sel   = 1'b0;
    #12;
    chk("reset in_ready", int'(in_ready), 0);
    chk("reset a_valid", int'(a_valid), 0);
    chk("reset b_valid", int'(b_valid), 0);
    chk("reset a_count", int'(a_count), 0);
    chk("reset b_count", int'(b_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("post-reset in_ready sel0", int'(in_ready), 1);
    in_sel = 1'b1;
    #1;
    chk("post-reset in_ready sel1", int'(in_ready), 1);

    // Directed table.
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].ar, tbl[i].br);
      chk($sformatf("row%0d in_ready", i), int'(in_ready), int'(tbl[i].e_rdy));
      chk($sformatf("row%0d a_valid", i), int'(a_valid), int'(tbl[i].e_av));
      if (tbl[i].e_av) chk($sformatf("row%0d a_data", i), int'(a_data), int'(tbl[i].e_ad));
      chk($sformatf("row%0d b_valid", i), int'(b_valid), int'(tbl[i].e_bv));
      if (tbl[i].e_bv) chk($sformatf("row%0d b_data", i), int'(b_data), int'(tbl[i].e_bd));
      model_check($sformatf("row%0d", i));
      step();
    end
    chk("route a_count", int'(a_count), 9);
    chk("route b_count", int'(b_count), 1);

    // Random traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom_range(0, (1 << W) - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
      model_check("rand");
      step();
    end

    // Counter wrap: fresh reset, 256 pushes into B.
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, W'(i), 1'b1, 1'b1, 1'b1);
      model_check("wrap");
      step();
    end
    drive(1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    chk("wrap b_count", int'(b_count), 0);
    chk("wrap a_count", int'(a_count), 0);
    step();

    // Reset mid-operation with words in both channels.
    drive(1'b1, 4'hC, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 4'hD, 1'b1, 1'b0, 1'b0); step();
    drive(1'b1, 4'hE, 1'b0, 1'b0, 1'b0);
    model_check("pre-reset");
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset a_valid", int'(a_valid), 0);
    chk("midreset b_valid", int'(b_valid), 0);
    chk("midreset a_count", int'(a_count), 0);
    chk("midreset b_count", int'(b_count), 0);
    chk("midreset in_ready", int'(in_ready), 0);
    model_reset();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 4'h0, 1'(i), 1'b1, 1'b1);
      model_check("after-reset");
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
